vending_ctrl: RTL and testbench
===============================

// Module: vending_ctrl
// PURPOSE
//  Parametrised vending controller, next generation of the fixed 20-unit coin FSM.
//  - Accumulates credit from three configurable coin denominations.
//  - Pulses a vend when credit reaches PRICE, then returns change one coin per valid/ready handshake.
//  - Adds cancel/refund, idle timeout, coin rejection and credit-overflow protection.
//  - Sits between the coin-acceptor front end and the product/change actuators.
// PARAMETERS
//  CREDIT_W  8    credit register width (bits)
//  PRICE     20   product price, credit units
//  COIN_A    5    value of coin_sel=0
//  COIN_B    10   value of coin_sel=1
//  COIN_C    25   value of coin_sel=2
//  CHG_UNIT  5    value of one returned change coin
//  TIMEOUT   255  idle cycles in COLLECT before automatic refund (>=1)
//  Elaboration check: PRICE and COIN_A/B/C are nonzero multiples of CHG_UNIT; PRICE < 2**CREDIT_W.
// PORTS
//  clk           in   1         rising-edge clock
//  rst_n         in   1         synchronous reset, active-low
//  coin_valid    in   1         coin present this cycle (single-cycle strobe per coin)
//  coin_sel      in   2         0=A, 1=B, 2=C, 3=invalid
//  cancel        in   1         request refund of current credit
//  change_ready  in   1         change actuator accepts one coin
//  change_valid  out  1         one CHG_UNIT coin offered
//  dispense      out  1         1-cycle vend pulse
//  coin_reject   out  1         1-cycle pulse: presented coin returned, credit unchanged
//  busy          out  1         high in VEND or CHANGE
//  credit        out  CREDIT_W  current credit
// BEHAVIOUR
//  Reset and registering
//  - rst_n=0 at a clk edge: state=IDLE, credit=0, timer=0.
//  - All outputs are 0 during reset and the cycle after.
//  - All outputs are registered or decoded from state only.
//  - rst_n low mid-VEND/CHANGE aborts immediately. Undelivered change is lost (documented).
//  States
//  - IDLE: accepted coin -> credit=value, go to COLLECT.
//  - COLLECT: accepted coin -> credit += value.
//    - Updated credit >= PRICE -> VEND next cycle.
//    - cancel=1 -> CHANGE, refunding the full credit. cancel wins over a same-cycle coin; that coin is rejected.
//    - No coin for TIMEOUT consecutive cycles -> CHANGE (refund).
//  - VEND: exactly one cycle.
//    - dispense=1; credit -= PRICE at exit.
//    - Exit to CHANGE if the remainder > 0, else IDLE.
//  - CHANGE: change_valid=1.
//    - Each cycle with change_ready=1: credit -= CHG_UNIT.
//    - Credit reaching 0 -> IDLE on that edge; change_valid drops the next cycle.
//    - change_valid stays high while change_ready is low (standard valid/ready, no drop).
//  Latency
//  - Coin sampled at edge N; credit visible at N+1.
//  - dispense asserts at N+1 when that coin crosses PRICE.
//  Rejection (coin_reject pulses the cycle after the coin)
//  - coin_sel=3.
//  - Any coin while busy.
//  - credit+value overflows CREDIT_W (sum computed CREDIT_W+1 wide).
//  - Coin coincident with cancel.
//  - Rejected coins do not restart the timeout.
//  Other rules
//  - cancel in IDLE, VEND or CHANGE is ignored.
//  - Timer: reset on every accepted coin and on entry to COLLECT; counts only in COLLECT; saturates.
// STRUCTURE
//  - vending_pkg: state enum (IDLE, COLLECT, VEND, CHANGE); coin_sel codes (COIN_SEL_A/B/C/BAD).
//  - Sub-module vend_idle_timer: parametrised TIMEOUT counter (clr, en -> expired).
//  - Credit add/subtract datapath and FSM stay in vending_ctrl.
// TESTING (defaults)
//  1. 10,10 -> credit 10 then 20; dispense 1 cycle at the second coin's N+1; IDLE; change_valid never high.
//  2. 5,25 -> dispense; credit 10; two change_valid handshakes (ready held high); then IDLE, credit 0.
//  3. 5,5, cancel -> no dispense; two change handshakes.
//     Repeat with change_ready low 3 cycles: change_valid held, credit stays 10.
//  4. Coin 10 then 255 idle cycles -> auto refund, 2 change coins.
//     Coin at cycle 254 restarts the timer instead.
//  5. coin_sel=3; coin during CHANGE; coin+cancel same cycle -> coin_reject each time, credit unchanged.
//  6. CREDIT_W=5 build: credit 25, add 10 -> rejected (overflow).
//     Reset asserted mid-CHANGE -> IDLE, all outputs 0.

Source files
------------

// File: rtl/vending_pkg.sv
// vending_pkg: shared FSM state encoding and coin-select codes for the vending controller
package vending_pkg;
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_VEND, S_CHANGE} state_t;
  localparam logic [1:0] COIN_SEL_A   = 2'd0;
  localparam logic [1:0] COIN_SEL_B   = 2'd1;
  localparam logic [1:0] COIN_SEL_C   = 2'd2;
  localparam logic [1:0] COIN_SEL_BAD = 2'd3;
endpackage

// File: rtl/vend_idle_timer.sv
// vend_idle_timer: saturating idle counter, o_expired once i_en has held for TIMEOUT-1 cycles since clear
// Ports: i_clk clock; i_rst_n sync active-low reset; i_clr restart count; i_en count this cycle;
//        o_expired high when the next idle edge is the TIMEOUT-th
module vend_idle_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
  logic [W-1:0] r_cnt;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) r_cnt <= '0;
    else if (i_en && r_cnt != LAST) r_cnt <= r_cnt + W'(1);
  end
  assign o_expired = r_cnt == LAST;
endmodule

// File: rtl/vending_ctrl.sv
// vending_ctrl: parametrised coin vending controller with change return, cancel, timeout and coin rejection
// Ports: i_clk clock; i_rst_n sync active-low reset; i_coin_valid/i_coin_sel coin strobe and type;
//        i_cancel refund request; i_change_ready change actuator ready; o_change_valid change coin offered;
//        o_dispense 1-cycle vend pulse; o_coin_reject 1-cycle reject pulse; o_busy in VEND/CHANGE;
//        o_credit current credit
module vending_ctrl #(
  parameter int CREDIT_W = 8,
  parameter int PRICE    = 20,
  parameter int COIN_A   = 5,
  parameter int COIN_B   = 10,
  parameter int COIN_C   = 25,
  parameter int CHG_UNIT = 5,
  parameter int TIMEOUT  = 255
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_coin_valid,
  input  logic [1:0]          i_coin_sel,
  input  logic                i_cancel,
  input  logic                i_change_ready,
  output logic                o_change_valid,
  output logic                o_dispense,
  output logic                o_coin_reject,
  output logic                o_busy,
  output logic [CREDIT_W-1:0] o_credit
);
  import vending_pkg::*;
  if (CHG_UNIT < 1 || PRICE < 1 || COIN_A < 1 || COIN_B < 1 || COIN_C < 1 || TIMEOUT < 1 ||
      PRICE % CHG_UNIT != 0 || COIN_A % CHG_UNIT != 0 || COIN_B % CHG_UNIT != 0 ||
      COIN_C % CHG_UNIT != 0 || PRICE >= 2 ** CREDIT_W) begin : g_param_check
    $error("vending_ctrl: illegal parameter set");
  end
  localparam logic [CREDIT_W:0]   PRICE_W = (CREDIT_W + 1)'(PRICE);
  localparam logic [CREDIT_W:0]   VAL_A   = (CREDIT_W + 1)'(COIN_A);
  localparam logic [CREDIT_W:0]   VAL_B   = (CREDIT_W + 1)'(COIN_B);
  localparam logic [CREDIT_W:0]   VAL_C   = (CREDIT_W + 1)'(COIN_C);
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] CHG_C   = CREDIT_W'(CHG_UNIT);
  state_t              r_state, w_next;
  logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
  logic                r_reject;
  logic [CREDIT_W:0]   w_val, w_sum;
  logic                w_accept, w_expired;
  vend_idle_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (w_accept),
    .i_en      (r_state == S_COLLECT),
    .o_expired (w_expired)
  );
  // Sum is one bit wider than credit so the carry flags overflow; in IDLE credit is 0, so sum is the coin value.
  always_comb begin
    w_val    = i_coin_sel == COIN_SEL_A ? VAL_A : i_coin_sel == COIN_SEL_B ? VAL_B : VAL_C;
    w_sum    = {1'b0, r_credit} + w_val;
    w_accept = i_coin_valid && i_coin_sel != COIN_SEL_BAD && !w_sum[CREDIT_W] &&
               (r_state == S_IDLE || (r_state == S_COLLECT && !i_cancel));
  end
  always_comb begin
    w_next       = r_state;
    w_credit_nxt = r_credit;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_credit_nxt = w_sum[CREDIT_W-1:0];
          w_next       = w_sum >= PRICE_W ? S_VEND : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (i_cancel) w_next = S_CHANGE;
        else if (w_accept) begin
          w_credit_nxt = w_sum[CREDIT_W-1:0];
          w_next       = w_sum >= PRICE_W ? S_VEND : S_COLLECT;
        end
        else if (w_expired) w_next = S_CHANGE;
      end
      S_VEND: begin
        w_credit_nxt = r_credit - PRICE_C;
        w_next       = r_credit == PRICE_C ? S_IDLE : S_CHANGE;
      end
      S_CHANGE: begin
        if (i_change_ready) begin
          w_credit_nxt = r_credit - CHG_C;
          w_next       = r_credit == CHG_C ? S_IDLE : S_CHANGE;
        end
      end
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_credit <= '0;
      r_reject <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_credit <= w_credit_nxt;
      r_reject <= i_coin_valid && !w_accept;
    end
  end
  assign o_dispense     = r_state == S_VEND;
  assign o_change_valid = r_state == S_CHANGE;
  assign o_busy         = r_state == S_VEND || r_state == S_CHANGE;
  assign o_coin_reject  = r_reject;
  assign o_credit       = r_credit;
endmodule

// File: tb/tb_vending_ctrl.sv
// tb_vending_ctrl: directed scoreboard bench for vending_ctrl (default build plus a CREDIT_W=5 build)
module tb_vending_ctrl;
  import vending_pkg::*;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_sel = 2'd0;
  logic       cancel = 1'b0;
  logic       change_ready = 1'b1;
  logic       cv1, d1, rj1, b1;
  logic [7:0] cr1;
  logic       cv2, d2, rj2, b2;
  logic [4:0] cr2;
  int         n_cmp = 0;
  int         n_err = 0;
  typedef struct {
    string      tag;
    bit         inst;
    logic [11:0] exp;
  } exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  vending_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_coin_valid(coin_valid), .i_coin_sel(coin_sel),
    .i_cancel(cancel), .i_change_ready(change_ready), .o_change_valid(cv1),
    .o_dispense(d1), .o_coin_reject(rj1), .o_busy(b1), .o_credit(cr1)
  );
  vending_ctrl #(.CREDIT_W(5), .PRICE(30)) dut_small (
    .i_clk(clk), .i_rst_n(rst_n), .i_coin_valid(coin_valid), .i_coin_sel(coin_sel),
    .i_cancel(cancel), .i_change_ready(change_ready), .o_change_valid(cv2),
    .o_dispense(d2), .o_coin_reject(rj2), .o_busy(b2), .o_credit(cr2)
  );
  task automatic step(input logic v, input logic [1:0] s, input logic c, input logic r,
                      input string tag, input int cr, input logic d, input logic cv,
                      input logic rj, input logic b, input bit inst = 1'b0);
    exp_t        e;
    logic [11:0] obs;
    sb.push_back('{tag, inst, {8'(cr), d, cv, rj, b}});
    coin_valid   = v;
    coin_sel     = s;
    cancel       = c;
    change_ready = r;
    @(posedge clk);
    #1;
    e   = sb.pop_front();
    obs = e.inst ? {3'b000, cr2, d2, cv2, rj2, b2} : {cr1, d1, cv1, rj1, b1};
    n_cmp++;
    assert (obs === e.exp) else begin
      n_err++;
      $error("FAIL %s: observed credit/disp/cv/rej/busy=%h expected %h", e.tag, obs, e.exp);
    end
    coin_valid = 1'b0;
    cancel     = 1'b0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end
  initial begin
    #2;
    step(0, 0, 0, 1, "rst0", 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, "rst1", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step(0, 0, 0, 1, "rst_after", 0, 0, 0, 0, 0);
    step(1, COIN_SEL_B, 0, 1, "t1_c1", 10, 0, 0, 0, 0);
    step(1, COIN_SEL_B, 0, 1, "t1_c2", 20, 1, 0, 0, 1);
    step(0, 0, 0, 1, "t1_idle", 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, "t1_idle2", 0, 0, 0, 0, 0);
    step(1, COIN_SEL_A, 0, 1, "t2_c1", 5, 0, 0, 0, 0);
    step(1, COIN_SEL_C, 0, 1, "t2_c2", 30, 1, 0, 0, 1);
    step(0, 0, 0, 1, "t2_vend_exit", 10, 0, 1, 0, 1);
    step(0, 0, 0, 1, "t2_h1", 5, 0, 1, 0, 1);
    step(0, 0, 0, 1, "t2_h2", 0, 0, 0, 0, 0);
    step(1, COIN_SEL_A, 0, 1, "t3_c1", 5, 0, 0, 0, 0);
    step(1, COIN_SEL_A, 0, 1, "t3_c2", 10, 0, 0, 0, 0);
    step(0, 0, 1, 1, "t3_cancel", 10, 0, 1, 0, 1);
    step(0, 0, 0, 1, "t3_h1", 5, 0, 1, 0, 1);
    step(0, 0, 0, 1, "t3_h2", 0, 0, 0, 0, 0);
    step(1, COIN_SEL_A, 0, 0, "t3b_c1", 5, 0, 0, 0, 0);
    step(1, COIN_SEL_A, 0, 0, "t3b_c2", 10, 0, 0, 0, 0);
    step(0, 0, 1, 0, "t3b_cancel", 10, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, "t3b_hold", 10, 0, 1, 0, 1);
    step(0, 0, 0, 1, "t3b_h1", 5, 0, 1, 0, 1);
    step(0, 0, 0, 1, "t3b_h2", 0, 0, 0, 0, 0);
    step(1, COIN_SEL_BAD, 0, 1, "t5_bad", 0, 0, 0, 1, 0);
    step(0, 0, 0, 1, "t5_bad_after", 0, 0, 0, 0, 0);
    step(1, COIN_SEL_A, 0, 0, "t5_c1", 5, 0, 0, 0, 0);
    step(1, COIN_SEL_A, 0, 0, "t5_c2", 10, 0, 0, 0, 0);
    step(0, 0, 1, 0, "t5_cancel", 10, 0, 1, 0, 1);
    step(1, COIN_SEL_A, 0, 0, "t5_busy", 10, 0, 1, 1, 1);
    step(0, 0, 0, 1, "t5_h1", 5, 0, 1, 0, 1);
    step(0, 0, 0, 1, "t5_h2", 0, 0, 0, 0, 0);
    step(1, COIN_SEL_A, 0, 1, "t5_cc_c1", 5, 0, 0, 0, 0);
    step(1, COIN_SEL_B, 1, 1, "t5_cc", 5, 0, 1, 1, 1);
    step(0, 0, 0, 1, "t5_cc_h", 0, 0, 0, 0, 0);
    step(1, COIN_SEL_B, 0, 1, "t4_c", 10, 0, 0, 0, 0);
    for (int i = 1; i <= 254; i++) step(0, 0, 0, 1, "t4_wait", 10, 0, 0, 0, 0);
    step(0, 0, 0, 1, "t4_timeout", 10, 0, 1, 0, 1);
    step(0, 0, 0, 1, "t4_h1", 5, 0, 1, 0, 1);
    step(0, 0, 0, 1, "t4_h2", 0, 0, 0, 0, 0);
    step(1, COIN_SEL_B, 0, 1, "t4b_c", 10, 0, 0, 0, 0);
    for (int i = 1; i <= 253; i++) step(0, 0, 0, 1, "t4b_wait", 10, 0, 0, 0, 0);
    step(1, COIN_SEL_A, 0, 1, "t4b_c254", 15, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, "t4b_restart", 15, 0, 0, 0, 0);
    step(0, 0, 1, 1, "t4b_cancel", 15, 0, 1, 0, 1);
    step(0, 0, 0, 1, "t4b_h1", 10, 0, 1, 0, 1);
    step(0, 0, 0, 1, "t4b_h2", 5, 0, 1, 0, 1);
    step(0, 0, 0, 1, "t4b_h3", 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    step(0, 0, 0, 1, "t6_rst", 0, 0, 0, 0, 0, 1'b1);
    rst_n = 1'b1;
    step(1, COIN_SEL_C, 0, 1, "t6_c25", 25, 0, 0, 0, 0, 1'b1);
    step(1, COIN_SEL_B, 0, 1, "t6_ovf", 25, 0, 0, 1, 0, 1'b1);
    step(1, COIN_SEL_A, 0, 1, "t6_c5", 30, 1, 0, 0, 1, 1'b1);
    step(0, 0, 0, 1, "t6_idle", 0, 0, 0, 0, 0, 1'b1);
    rst_n = 1'b0;
    step(0, 0, 0, 1, "t7_rst", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step(1, COIN_SEL_A, 0, 0, "t7_c1", 5, 0, 0, 0, 0);
    step(1, COIN_SEL_A, 0, 0, "t7_c2", 10, 0, 0, 0, 0);
    step(0, 0, 1, 0, "t7_cancel", 10, 0, 1, 0, 1);
    rst_n = 1'b0;
    step(0, 0, 0, 0, "t7_abort", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step(0, 0, 0, 1, "t7_after", 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, "t7_idle", 0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
